// File: rtl/priority_arbiter.sv
// priority_arbiter: request/grant arbiter driving the one-hot select of the
// priority decision-tree muxes. Grants are registered, held until release or
// hold-timeout, and always followed by a one-cycle turnaround gap.
// Optional feature: define PRIORITY_ARBITER_ROUND_ROBIN_EN to rotate priority
// starting after the last grantee; otherwise fixed priority, index 0 highest.
module priority_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_done,
  output logic [N_REQ-1:0]           o_gnt,
  output logic                       o_gntValid,
  output logic [$clog2(N_REQ)-1:0]   o_gntIdx,
  output logic                       o_preempt
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] MaxHoldC = CntW'(MAX_HOLD);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   win_idx;
  logic [N_REQ-1:0]  win_onehot;
  logic              any_req;
  logic              grantee_release;

`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
  logic [IdxW-1:0]   ptr_q;
`endif

  // Winner selection; later loop iterations override earlier ones, so the
  // last match written is the highest-priority requester.
  always_comb begin
    win_idx = '0;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
    for (int off = int'(N_REQ); off >= 1; off--) begin
      if (i_req[(int'(ptr_q) + off) % int'(N_REQ)]) begin
        win_idx = IdxW'((int'(ptr_q) + off) % int'(N_REQ));
      end
    end
`else
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        win_idx = IdxW'(i);
      end
    end
`endif
    win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    any_req    = |i_req;
  end

  // Only the current grantee's request and done bits matter while granted.
  always_comb begin
    grantee_release = ~i_req[o_gntIdx] | i_done[o_gntIdx];
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      o_gnt      <= '0;
      o_gntValid <= 1'b0;
      o_gntIdx   <= '0;
      o_preempt  <= 1'b0;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
      ptr_q      <= LastIdx;
`endif
    end else begin
      o_preempt <= 1'b0;
      unique case (state_q)
        StIdle, StRelease: begin
          if (any_req) begin
            state_q    <= StGrant;
            cnt_q      <= CntW'(1);
            o_gnt      <= win_onehot;
            o_gntValid <= 1'b1;
            o_gntIdx   <= win_idx;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
            ptr_q      <= win_idx;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (grantee_release) begin
            // Voluntary release wins over a coincident timeout: no preempt.
            state_q    <= StRelease;
            cnt_q      <= '0;
            o_gnt      <= '0;
            o_gntValid <= 1'b0;
            o_gntIdx   <= '0;
          end else if ((MAX_HOLD != 0) && (cnt_q == MaxHoldC)) begin
            state_q    <= StRelease;
            cnt_q      <= '0;
            o_gnt      <= '0;
            o_gntValid <= 1'b0;
            o_gntIdx   <= '0;
            o_preempt  <= 1'b1;
          end else if (MAX_HOLD != 0) begin
            // Counter stops at MAX_HOLD via the timeout above, so no wrap.
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q    <= StIdle;
          cnt_q      <= '0;
          o_gnt      <= '0;
          o_gntValid <= 1'b0;
          o_gntIdx   <= '0;
        end
      endcase
    end
  end

`ifndef PRIORITY_ARBITER_ROUND_ROBIN_EN
  // Reset pointer value only matters for rotating priority.
  logic unused_last_idx;
  assign unused_last_idx = ^LastIdx;
`endif

endmodule

// File: doc/priority_arbiter.md
Name: priority_arbiter

Overview:
- Request/grant arbiter that generates the one-hot select consumed by the team's priority decision-tree muxes, i.e. the controlling end of that select interface.
- N requesters raise i_req. The block issues a registered one-hot grant, holds it until release or hold-timeout, then re-arbitrates.
- Default policy is fixed priority with index 0 highest, matching the mux priority order.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 15, maximum cycles a grant may be held before forced preemption; 0 = unlimited.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_req  input  N_REQ  per-requester request level.
- i_done  input  N_REQ  per-requester release pulse; only the bit of the current grantee is sampled.
- o_gnt  output  N_REQ  registered one-hot grant; all-zero when no grant.
- o_gntValid  output  1  high when o_gnt is non-zero.
- o_gntIdx  output  $clog2(N_REQ)  binary index of the grantee; 0 when o_gntValid is low.
- o_preempt  output  1  one-cycle pulse when a grant is removed by timeout.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values: o_gnt=0, o_gntValid=0, o_gntIdx=0, o_preempt=0, state=IDLE, hold counter=0, last-grant pointer=N_REQ-1.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: if i_req != 0, select the winner and go to GRANT. o_gnt asserts on the next edge, so request-to-grant latency is 1 cycle.
  - GRANT: the grant is held and the hold counter increments each cycle, starting at 1 in the first grant cycle.
    - Release: i_req[idx]==0 or i_done[idx]==1 -> RELEASE.
    - Timeout: if MAX_HOLD!=0 and counter==MAX_HOLD and no release that cycle -> RELEASE, with o_preempt=1 during the first RELEASE cycle.
    - Release takes precedence over timeout in the same cycle; o_preempt stays 0.
  - RELEASE: o_gnt=0 for exactly one cycle (bus turnaround). If i_req != 0, arbitrate and go to GRANT; else go to IDLE. Minimum gap between two grants is 1 cycle.
- Winner selection (fixed priority): lowest set index of i_req.
- With MAX_HOLD=0, the grant persists indefinitely while i_req[idx] is high and no i_done arrives.
- Hold counter width: $clog2(MAX_HOLD+1), minimum 1. It cannot wrap: timeout fires at MAX_HOLD, and the counter clears on entry to GRANT.
- i_done bits of non-grantees are ignored. i_req changes on other lines during GRANT do not affect the grant.
- i_rst mid-grant: outputs clear on the same edge; the next grant follows normal IDLE latency.
- o_gnt is always one-hot or zero (assertion in bench).

Optional Feature:
- Macro: PRIORITY_ARBITER_ROUND_ROBIN_EN.
- Defined: the winner is the first set i_req scanning upward from (last-grant pointer + 1) mod N_REQ. The pointer updates to the winner index on every grant. A preempted requester therefore loses to any other active requester.
- Undefined: fixed priority with index 0 highest. The pointer logic is not synthesized.

Test Plan (N_REQ=4, MAX_HOLD=4 unless stated):
- Reset then i_req=4'b1010 -> one cycle later o_gnt=4'b0010, o_gntIdx=1, o_gntValid=1.
- Grantee 1 pulses i_done at grant cycle 2 -> next cycle o_gnt=0, o_preempt=0. With i_req=4'b1000 still high, the following cycle o_gnt=4'b1000.
- i_req=4'b0001 held with no i_done -> grant for exactly 4 cycles, then RELEASE with o_preempt=1 for 1 cycle, then o_gnt=4'b0001 again (fixed priority).
- Same stimulus with i_req=4'b0101 and PRIORITY_ARBITER_ROUND_ROBIN_EN defined -> sequence 0001, 0000, 0100, 0000, 0001; o_preempt pulses at each gap.
- i_done[idx] and timeout coincide at counter==4 -> RELEASE with o_preempt=0.
- i_rst asserted during GRANT with i_req=4'b1111 -> same edge all outputs 0. After i_rst deasserts, o_gnt=4'b0001 one cycle later.
- MAX_HOLD=0, i_req=4'b0010 held for 100 cycles -> o_gnt stays 4'b0010 throughout, with no preemption.
